// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry defaults and the receiver state encoding.
// The transmitter and the baud generator pick up the same defaults from here.
package uart_pkg;

    // Payload bits per frame (8N1).
    localparam int UART_DATA_BITS = 8;

    // Oversample ticks per bit period; must be even and at least 4.
    localparam int UART_OVERSAMPLE = 16;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;

    // Tick count at which the start bit is re-checked: half a bit after the edge.
    function automatic int half_bit_tick(input int oversample);
        return (oversample / 2) - 1;
    endfunction

    // Tick count at which a data or stop bit is sampled: one full bit later.
    function automatic int full_bit_tick(input int oversample);
        return oversample - 1;
    endfunction

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous input, with a configurable
// reset value so an idle-high serial line does not look like a start edge
// coming out of reset.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. The serial line is synchronised, then a
// small FSM driven by the oversample strobe finds the start edge, re-checks
// it half a bit later, and samples each following bit one bit period apart,
// which lands every sample on the bit centre. A good stop bit publishes the
// byte with a one-cycle valid pulse; a low stop bit raises a one-cycle
// framing-error pulse and parks in BREAK until the line returns high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 OversampleTick,
    input  logic                 RxSerial,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    output logic                 FramingError,
    output logic                 RxBusy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(half_bit_tick(OVERSAMPLE));
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(full_bit_tick(OVERSAMPLE));

    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;

    // The line idles high, so the synchroniser also resets high.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (Clock),
        .rst_i (Reset),
        .d_i   (RxSerial),
        .q_o   (rx_s)
    );

    // Frame-tracking FSM with registered data, pulse and busy outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= TICK_ZERO;
            bit_cnt_q  <= BIT_ZERO;
            shreg_q    <= {DATA_BITS{1'b0}};
            data_q     <= {DATA_BITS{1'b0}};
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // Pulses last exactly one Clock, independent of the tick rate.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;

            if (OversampleTick) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_s) begin
                            state_q    <= START;
                            tick_cnt_q <= TICK_ZERO;
                            busy_q     <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick_cnt_q == TICK_HALF) begin
                            if (!rx_s) begin
                                // Still low at mid start bit: a real frame.
                                state_q    <= DATA;
                                tick_cnt_q <= TICK_ZERO;
                                bit_cnt_q  <= BIT_ZERO;
                            end else begin
                                // Short glitch on the line: drop it silently.
                                state_q    <= IDLE;
                                tick_cnt_q <= TICK_ZERO;
                                busy_q     <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TICK_ONE;
                        end
                    end

                    DATA: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            // Right shift: the first (LSB) bit ends up in bit 0.
                            shreg_q    <= {rx_s, shreg_q[DATA_BITS-1:1]};
                            tick_cnt_q <= TICK_ZERO;
                            bit_cnt_q  <= bit_cnt_q + BIT_ONE;
                            if (bit_cnt_q == BIT_LAST) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TICK_ONE;
                        end
                    end

                    STOP: begin
                        if (tick_cnt_q == TICK_LAST) begin
                            tick_cnt_q <= TICK_ZERO;
                            bit_cnt_q  <= BIT_ZERO;
                            if (rx_s) begin
                                // Back to IDLE at the stop centre so an early
                                // next start edge is still caught.
                                data_q  <= shreg_q;
                                valid_q <= 1'b1;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= BREAK;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + TICK_ONE;
                        end
                    end

                    BREAK: begin
                        // A held-low line must not look like a new start bit.
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end

                    default: begin
                        state_q    <= IDLE;
                        tick_cnt_q <= TICK_ZERO;
                        bit_cnt_q  <= BIT_ZERO;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign RxData       = data_q;
    assign RxValid      = valid_q;
    assign FramingError = ferr_q;
    assign RxBusy       = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames with a tick-offset reference model of
// the receiver, compared every Clock, plus hand-computed literal checks.
module tb_uart_rx;

    localparam int OS        = 16;
    localparam int BIT_CLKS  = 64;
    localparam int HALF_OFF  = OS / 2;
    localparam int STOP_OFF  = OS / 2 + 9 * OS;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       OversampleTick;
    logic       RxSerial;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FramingError;
    logic       RxBusy;

    uart_rx dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .OversampleTick (OversampleTick),
        .RxSerial       (RxSerial),
        .RxData         (RxData),
        .RxValid        (RxValid),
        .FramingError   (FramingError),
        .RxBusy         (RxBusy)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model state: line delay, frame position in ticks since the edge.
    logic       m_s1, m_s2;
    logic       m_active, m_break;
    int         m_off;
    logic [7:0] m_bits, m_data;
    logic       m_valid, m_ferr;

    // Observed-pulse bookkeeping for the literal checks.
    int         n_valid, n_ferr, busy_cycles;
    int         last_valid_cyc, prev_valid_cyc;
    logic       busy_at_valid;
    logic [7:0] got_data[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1;
        m_active = 1'b0; m_break = 1'b0; m_off = 0;
        m_bits = 8'h00; m_data = 8'h00;
        m_valid = 1'b0; m_ferr = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input logic rx, input logic tick);
        logic v;
        v = m_s2;
        m_s2 = m_s1;
        m_s1 = rx;
        m_valid = 1'b0;
        m_ferr = 1'b0;
        if (tick) begin
            if (m_break) begin
                if (v) m_break = 1'b0;
            end else if (!m_active) begin
                if (!v) begin
                    m_active = 1'b1;
                    m_off = 0;
                end
            end else begin
                m_off++;
                if (m_off == HALF_OFF) begin
                    if (v) m_active = 1'b0;
                end else if (m_off == STOP_OFF) begin
                    m_active = 1'b0;
                    if (v) begin
                        m_data = m_bits;
                        m_valid = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                        m_break = 1'b1;
                    end
                end else if ((m_off - HALF_OFF) % OS == 0) begin
                    m_bits[(m_off - HALF_OFF) / OS - 1] = v;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic m_busy;
        m_busy = m_active | m_break;
        vectors++;
        if ({RxData, RxValid, FramingError, RxBusy} !== {m_data, m_valid, m_ferr, m_busy}) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got data=%02h v=%b fe=%b busy=%b expected data=%02h v=%b fe=%b busy=%b",
                     cyc, RxData, RxValid, FramingError, RxBusy, m_data, m_valid, m_ferr, m_busy);
        end
        if (RxValid === 1'b1) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            busy_at_valid  = RxBusy;
            got_data.push_back(RxData);
        end
        if (FramingError === 1'b1) n_ferr++;
        if (RxBusy === 1'b1) busy_cycles++;
    endtask

    // One Clock: check outputs of the last edge, then set up the next one.
    task automatic step(input logic rx, input logic rst_v);
        compare_outputs();
        OversampleTick = (cyc % 4 == 0);
        RxSerial = rx;
        Reset = rst_v;
        if (rst_v) model_reset();
        else model_edge(rx, OversampleTick);
        @(negedge Clock);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb, input int bitlen);
        logic val;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) val = 1'b0;
            else if (i == 9) val = stopb;
            else val = b[i-1];
            repeat (bitlen) step(val, 1'b0);
        end
    endtask

    task automatic clear_stats();
        n_valid = 0; n_ferr = 0; busy_cycles = 0;
        last_valid_cyc = 0; prev_valid_cyc = 0;
        busy_at_valid = 1'bx;
        got_data.delete();
    endtask

    initial begin
        Reset = 1'b1;
        RxSerial = 1'b1;
        OversampleTick = 1'b0;
        model_reset();
        clear_stats();
        @(negedge Clock);

        repeat (3) step(1'b1, 1'b1);
        check("reset RxData", {24'h0, RxData}, 32'h0);
        check("reset RxValid", {31'h0, RxValid}, 32'h0);
        check("reset FramingError", {31'h0, FramingError}, 32'h0);
        check("reset RxBusy", {31'h0, RxBusy}, 32'h0);
        idle(20);

        // T1: clean 0xA5 frame.
        clear_stats();
        send_frame(8'hA5, 1'b1, BIT_CLKS);
        idle(64);
        check("T1 valid pulses", n_valid, 32'd1);
        check("T1 framing pulses", n_ferr, 32'd0);
        check("T1 RxData", {24'h0, RxData}, 32'hA5);
        check("T1 busy low with valid", {31'h0, busy_at_valid}, 32'h0);

        // T2: 4-tick low glitch; busy spans detection to the half-bit re-check.
        clear_stats();
        repeat (16) step(1'b0, 1'b0);
        idle(200);
        check("T2 valid pulses", n_valid, 32'd0);
        check("T2 framing pulses", n_ferr, 32'd0);
        check("T2 busy cycles", busy_cycles, 32'd32);
        check("T2 RxData kept", {24'h0, RxData}, 32'hA5);

        // T3: bad stop bit, line held low three more bit times.
        clear_stats();
        send_frame(8'h3C, 1'b0, BIT_CLKS);
        repeat (3 * BIT_CLKS) step(1'b0, 1'b0);
        check("T3 busy in break", {31'h0, RxBusy}, 32'h1);
        idle(200);
        check("T3 framing pulses", n_ferr, 32'd1);
        check("T3 valid pulses", n_valid, 32'd0);
        check("T3 RxData kept", {24'h0, RxData}, 32'hA5);
        check("T3 busy after release", {31'h0, RxBusy}, 32'h0);

        // T4: 0x00 then 0xFF with no idle gap.
        clear_stats();
        send_frame(8'h00, 1'b1, BIT_CLKS);
        send_frame(8'hFF, 1'b1, BIT_CLKS);
        idle(100);
        check("T4 valid pulses", n_valid, 32'd2);
        check("T4 pulse spacing", last_valid_cyc - prev_valid_cyc, 32'd640);
        if (got_data.size() == 2) begin
            check("T4 first byte", {24'h0, got_data[0]}, 32'h00);
            check("T4 second byte", {24'h0, got_data[1]}, 32'hFF);
        end

        // T5: reset mid bit 4 of 0x55, then 0x81.
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            repeat (BIT_CLKS) step((i == 0) ? 1'b0 : ((i % 2 == 1) ? 1'b1 : 1'b0), 1'b0);
        end
        repeat (BIT_CLKS / 2) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("T5 RxData after reset", {24'h0, RxData}, 32'h0);
        check("T5 RxBusy after reset", {31'h0, RxBusy}, 32'h0);
        idle(700);
        check("T5 aborted frame pulses", n_valid + n_ferr, 32'd0);
        send_frame(8'h81, 1'b1, BIT_CLKS);
        idle(64);
        check("T5 valid pulses", n_valid, 32'd1);
        check("T5 RxData", {24'h0, RxData}, 32'h81);

        // T6: 0x96 at fast and slow baud.
        clear_stats();
        send_frame(8'h96, 1'b1, 62);
        idle(100);
        check("T6 fast RxData", {24'h0, RxData}, 32'h96);
        send_frame(8'h96, 1'b1, 66);
        idle(100);
        check("T6 valid pulses", n_valid, 32'd2);
        check("T6 framing pulses", n_ferr, 32'd0);
        check("T6 slow RxData", {24'h0, RxData}, 32'h96);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_rx
